// File: rtl/step_clock_gen.sv
// Debounced single-step / free-run clock source for a slow processor under test.
// Define STEP_COUNTER_EN to build the 16-bit step_count register; otherwise step_count reads 0.
module step_clock_gen #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RUN_DIV         = 25000000,
   parameter int HIGH_CYCLES     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_n,
   input  logic        run_sw,
   input  logic        halt,
   output logic        cpu_clk,
   output logic        step_pulse,
   output logic        busy,
   output logic [15:0] step_count
);

   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam int PH_W  = (HIGH_CYCLES > 1) ? $clog2(HIGH_CYCLES) : 1;

   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);
   localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(HIGH_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      HI,
      LO
   } state_t;

   logic [1:0]       btn_sync;
   logic [1:0]       run_sync;
   logic             btn_s;
   logic             run_mode;
   logic [DB_W-1:0]  db_cnt;
   logic             db_lvl;
   logic             db_lvl_q;
   logic             press;
   logic [DIV_W-1:0] div_cnt;
   logic             run_tick;
   logic             trigger;
   state_t           state;
   state_t           state_nx;
   logic [PH_W-1:0]  ph_cnt;
   logic [PH_W-1:0]  ph_cnt_nx;
   logic             phase_done;
   logic             start;

   // Both raw inputs are asynchronous; the button idles released (1), the switch in manual (0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_sync <= 2'b11;
         run_sync <= 2'b00;
      end else begin
         btn_sync <= {btn_sync[0], btn_n};
         run_sync <= {run_sync[0], run_sw};
      end
   end

   assign btn_s    = btn_sync[1];
   assign run_mode = run_sync[1];

   // Level is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt   <= '0;
         db_lvl   <= 1'b1;
         db_lvl_q <= 1'b1;
      end else begin
         db_lvl_q <= db_lvl;
         if (btn_s == db_lvl) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_MAX) begin
            db_cnt <= '0;
            db_lvl <= btn_s;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign press = db_lvl_q & ~db_lvl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (!run_mode || div_cnt == DIV_MAX) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign run_tick = run_mode & (div_cnt == DIV_MAX);
   assign trigger  = ~halt & ((press & ~run_mode) | (run_tick & run_mode));

   assign phase_done = (ph_cnt == PH_MAX);

   // Triggers are only looked at in IDLE, so anything arriving mid-step is dropped.
   always_comb begin
      state_nx  = state;
      ph_cnt_nx = ph_cnt;
      start     = 1'b0;
      case (state)
         IDLE: begin
            ph_cnt_nx = '0;
            if (trigger) begin
               state_nx = HI;
               start    = 1'b1;
            end
         end
         HI: begin
            if (phase_done) begin
               state_nx  = LO;
               ph_cnt_nx = '0;
            end else begin
               ph_cnt_nx = ph_cnt + 1'b1;
            end
         end
         LO: begin
            if (phase_done) begin
               state_nx  = IDLE;
               ph_cnt_nx = '0;
            end else begin
               ph_cnt_nx = ph_cnt + 1'b1;
            end
         end
         default: begin
            state_nx  = IDLE;
            ph_cnt_nx = '0;
         end
      endcase
   end

   // cpu_clk and step_pulse come straight from flops fed by next-state logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ph_cnt     <= '0;
         cpu_clk    <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         state      <= state_nx;
         ph_cnt     <= ph_cnt_nx;
         cpu_clk    <= (state_nx == HI);
         step_pulse <= start;
      end
   end

   assign busy = (state != IDLE);

`ifdef STEP_COUNTER_EN
   logic [15:0] step_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_cnt <= 16'h0000;
      end else if (step_pulse) begin
         step_cnt <= step_cnt + 16'h0001;
      end
   end

   assign step_count = step_cnt;
`else
   assign step_count = 16'h0000;
`endif

endmodule

// File: tb/tb_step_clock_gen.sv
// Randomized bench for step_clock_gen with a cycle-indexed behavioural model and directed scenarios.
module tb_step_clock_gen;

   localparam int D = 4;
   localparam int R = 20;
   localparam int H = 2;
`ifdef STEP_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_n = 1'b1;
   logic        run_sw = 1'b0;
   logic        halt = 1'b0;
   logic        cpu_clk;
   logic        step_pulse;
   logic        busy;
   logic [15:0] step_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   step_clock_gen #(
      .DEBOUNCE_CYCLES(D),
      .RUN_DIV(R),
      .HIGH_CYCLES(H)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_n(btn_n),
      .run_sw(run_sw),
      .halt(halt),
      .cpu_clk(cpu_clk),
      .step_pulse(step_pulse),
      .busy(busy),
      .step_count(step_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: b_hist/r_hist hold raw inputs of the last two cycles ([1] is the older = synced value),
   // win holds the synced button over the last D cycles, s is the cycle index of the current/last step start.
   bit          b_hist[2];
   bit          r_hist[2];
   bit          win[$];
   bit          lvl, lvl_prev, sb, sr, all_diff, m_press, m_tick, trig;
   bit          e_busy, e_cpu, e_pulse;
   int          run_len;
   int          n = 0;
   int          s;
   logic [15:0] m_cnt;

   task automatic m_reset();
      b_hist[0] = 1'b1; b_hist[1] = 1'b1;
      r_hist[0] = 1'b0; r_hist[1] = 1'b0;
      win.delete();
      for (int i = 0; i < D; i++) win.push_back(1'b1);
      lvl = 1'b1;
      run_len = 0;
      s = -1000;
      m_cnt = 16'h0000;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         m_reset();
         chk("rst_cpu_clk", cpu_clk, 0);
         chk("rst_pulse", step_pulse, 0);
         chk("rst_busy", busy, 0);
         chk("rst_count", step_count, 0);
      end else begin
         sb = b_hist[1];
         sr = r_hist[1];
         all_diff = 1'b1;
         foreach (win[i]) if (win[i] == lvl) all_diff = 1'b0;
         lvl_prev = lvl;
         if (all_diff) lvl = ~lvl;
         m_press = lvl_prev && !lvl;
         run_len = sr ? run_len + 1 : 0;
         m_tick  = sr && (run_len % R == 0);
         e_busy  = (n >= s) && (n < s + 2 * H);
         e_cpu   = (n >= s) && (n < s + H);
         e_pulse = (n == s);
         chk("cpu_clk", cpu_clk, e_cpu);
         chk("step_pulse", step_pulse, e_pulse);
         chk("busy", busy, e_busy);
         chk("step_count", step_count, CNT_EN ? m_cnt : 16'h0000);
         trig = !e_busy && !halt && (sr ? m_tick : m_press);
         if (trig) s = n + 1;
         if (e_pulse) m_cnt = m_cnt + 16'h0001;
         win.push_back(sb);
         void'(win.pop_front());
         b_hist[1] = b_hist[0]; b_hist[0] = btn_n;
         r_hist[1] = r_hist[0]; r_hist[0] = run_sw;
      end
      n++;
   end

   // Leaves the caller just after a rising edge, where inputs are driven.
   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic watch(input int k, output int np, output int nh, output int span);
      int first, last;
      np = 0; nh = 0; first = -1; last = -1;
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         if (step_pulse) begin
            np++;
            if (first < 0) first = i;
            last = i;
         end
         if (cpu_clk) nh++;
      end
      span = last - first;
      cyc(1);
   endtask

   task automatic wait_pulse(input string nm, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = step_pulse;
      end
      chk(nm, seen, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int np, nh, sp, np2, nh2;
      logic [15:0] base;
      cyc(3);
      chk("reset_cpu_clk", cpu_clk, 0);
      chk("reset_busy", busy, 0);
      chk("reset_count", step_count, 0);
      rst = 1'b0;
      cyc(2);

      // Clean press: exactly one step, two high cycles.
      btn_n = 1'b0;
      watch(10, np, nh, sp);
      btn_n = 1'b1;
      watch(20, np2, nh2, sp);
      chk("press_pulses", np + np2, 1);
      chk("press_high_cycles", nh + nh2, H);
      chk("press_count", step_count, CNT_EN ? 16'd1 : 16'd0);

      // Short glitch must be ignored.
      btn_n = 1'b0;
      cyc(2);
      btn_n = 1'b1;
      watch(20, np, nh, sp);
      chk("glitch_pulses", np, 0);
      chk("glitch_high", nh, 0);

      // Free run for 100 cycles.
      base = step_count;
      run_sw = 1'b1;
      fork
         begin cyc(100); run_sw = 1'b0; end
         watch(110, np, nh, sp);
      join
      chk("run_pulses", np, 5);
      chk("run_span", sp, 4 * R);
      chk("run_count", step_count - base, CNT_EN ? 16'd5 : 16'd0);

      // Halt raised one cycle after a pulse: step completes, nothing more.
      run_sw = 1'b1;
      wait_pulse("halt_first_pulse", 60);
      @(posedge clk); #1;
      halt = 1'b1;
      watch(40, np, nh, sp);
      chk("halt_high_remaining", nh, H - 1);
      chk("halt_pulses", np, 0);
      halt = 1'b0;
      run_sw = 1'b0;
      watch(10, np, nh, sp);

      // Asynchronous reset during HI.
      btn_n = 1'b0;
      cyc(6);
      btn_n = 1'b1;
      wait_pulse("rst_mid_pulse", 20);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_cpu_clk", cpu_clk, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_count", step_count, 0);
      cyc(2);
      rst = 1'b0;
      watch(20, np, nh, sp);
      chk("post_rst_pulses", np, 0);
      chk("post_rst_busy", busy, 0);

`ifdef STEP_COUNTER_EN
      // Counter wrap from 0xFFFF.
      force dut.step_cnt = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1 release dut.step_cnt;
      cyc(1);
      btn_n = 1'b0;
      cyc(8);
      btn_n = 1'b1;
      watch(20, np, nh, sp);
      chk("wrap_pulses", np, 1);
      chk("wrap_count", step_count, 16'h0000);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(99) < 10) btn_n = ~btn_n;
         if ($urandom_range(199) == 0) run_sw = ~run_sw;
         if ($urandom_range(99) < 3) halt = ~halt;
         rst = ($urandom_range(999) < 3);
         cyc(1);
      end
      rst = 1'b0;
      cyc(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/step_clock_gen.md
STEP_CLOCK_GEN -- requirements
Module: step_clock_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of clk cycles the synchronized button must stay stable before it is accepted (10 ms at 50 MHz).
REQ-002 Parameter RUN_DIV, default 25000000, is the number of clk cycles between auto-step triggers in run mode.
REQ-003 Parameter HIGH_CYCLES, default 16, is the number of clk cycles cpu_clk stays high and then low per step.
REQ-004 clk  input  1  board clock (CLOCK_50 domain); all state is rising-edge clocked.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_n  input  1  raw push button, active-low, asynchronous to clk.
REQ-007 run_sw  input  1  raw slide switch, asynchronous: 0 = manual single-step, 1 = free-run.
REQ-008 halt  input  1  synchronous to clk; when 1, new steps are blocked.
REQ-009 cpu_clk  output  1  registered processor clock driven into the processor's clk port.
REQ-010 step_pulse  output  1  one-cycle strobe, coincident with the first cycle of cpu_clk high.
REQ-011 busy  output  1  1 whenever the FSM is not IDLE.
REQ-012 step_count  output  16  number of steps issued since reset.

Function
REQ-013 btn_n and run_sw SHALL each pass through a two-flop synchronizer before any other use.
REQ-014 The debouncer SHALL update its stable level only after the synchronized button has held a new value for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-015 A press event SHALL be a 1->0 transition of the debounced btn_n and SHALL last one cycle.
REQ-016 In run mode, the run divider SHALL count 0..RUN_DIV-1 and emit a one-cycle tick on wrap; in manual mode it SHALL be held at 0.
REQ-017 Trigger = (press event AND manual mode) OR (run tick AND run mode), gated by halt=0.
REQ-018 FSM states: IDLE, HI, LO; IDLE->HI on trigger; HI->LO after HIGH_CYCLES cycles; LO->IDLE after HIGH_CYCLES cycles.
REQ-019 cpu_clk SHALL be 1 in HI and 0 in IDLE and LO, registered with no combinational path from inputs.
REQ-020 cpu_clk SHALL rise on the clock edge following the trigger cycle, and step_pulse SHALL assert in that same cycle.
REQ-021 Triggers arriving while busy=1 SHALL be dropped, not queued.
REQ-022 halt asserting mid-step SHALL NOT truncate the current HI/LO sequence.
REQ-023 A run_sw change mid-step SHALL NOT truncate the current step; the new mode applies from the next trigger.
REQ-024 step_count SHALL increment by 1 on each step_pulse and wrap 0xFFFF->0x0000.

Reset
REQ-025 While rst=1: FSM=IDLE, cpu_clk=0, step_pulse=0, busy=0, step_count=0, divider and debounce counters=0, synchronizers and debounced level=1 (button released), run_sw synchronizer=0.
REQ-026 Reset asserted mid-step SHALL force cpu_clk low immediately (asynchronously); after release, no step SHALL occur until a new trigger.

Configuration
REQ-027 Macro STEP_COUNTER_EN: when defined, step_count is implemented per REQ-024; when undefined, step_count is tied to 16'h0000, no counter register exists, and all other behaviour is unchanged.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=20, HIGH_CYCLES=2, STEP_COUNTER_EN defined)
REQ-028 Button held low for 10 cycles in manual mode -> exactly one step_pulse; cpu_clk high 2 cycles then low 2; step_count=1.
REQ-029 Button glitch low for 2 cycles -> no step_pulse; cpu_clk stays 0.
REQ-030 run_sw=1 for 100 cycles -> 5 step_pulses spaced 20 cycles apart; step_count=5.
REQ-031 Run mode with halt=1 raised 1 cycle after a step_pulse -> current step completes (2 high, 2 low); no further pulses while halt=1.
REQ-032 rst pulsed during HI -> cpu_clk=0 in the same cycle; step_count=0; busy=0 after release.
REQ-033 step_count preloaded by forcing to 0xFFFF, then one press -> step_count=0x0000; build without the macro -> step_count constant 0.
